// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder, LSB first,
// one bit per clock, with sum, carry-out and signed overflow on completion.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             c_msb_in;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as a + ~b + 1: carry-in supplies the +1
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == PRE) begin
                        c_msb_in <= fa_c;
                    end
                    if (cnt == LAST) begin
                        sum   <= {fa_s, res_sr[WIDTH-1:1]};
                        cout  <= fa_c;
                        ovf   <= c_msb_in ^ fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: arithmetic vectors, timing,
// back-to-back start, operand stability and mid-operation reset.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Launch one op, scramble inputs after acceptance, wait for done.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         input logic s, output int busy_cyc,
                         output bit done_ok);
        @(negedge clk);
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x;
        b = x ^ y;
        sub = ~s;
        busy_cyc = 0;
        done_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_ok = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic check_res(input string name, input logic [7:0] es,
                             input logic ec, input logic eo, input bit ok);
        // Result comparison for an op that already finished
        total++;
        if (!ok) $display("FAIL %s timeout: no done pulse", name);
        else if ({sum, cout, ovf} !== {es, ec, eo})
            $display("FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, es, ec, eo);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, sum, cout, ovf} !== 12'h000)
            $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        else passed++;
    endtask

    task automatic test_add_timing();
        int bc;
        bit ok;
        do_op(8'h5A, 8'h3C, 1'b0, bc, ok);
        total++;
        if (bc !== 8) $display("FAIL busy_len: got %0d, want 8", bc);
        else passed++;
        check_res("add_5a_3c", 8'h96, 1'b0, 1'b1, ok);
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL done_width: got done=%b, want 0", done);
        else passed++;
        total++;
        if (sum !== 8'h96) $display("FAIL sum_hold: got %h, want 96", sum);
        else passed++;
    endtask

    task automatic test_add_carry();
        int bc;
        bit ok;
        do_op(8'hFF, 8'h01, 1'b0, bc, ok);
        check_res("add_ff_01", 8'h00, 1'b1, 1'b0, ok);
    endtask

    task automatic test_sub();
        int bc;
        bit ok;
        do_op(8'h10, 8'h20, 1'b1, bc, ok);
        check_res("sub_10_20", 8'hF0, 1'b0, 1'b0, ok);
        do_op(8'h80, 8'h01, 1'b1, bc, ok);
        check_res("sub_80_01", 8'h7F, 1'b1, 1'b1, ok);
    endtask

    task automatic test_operand_change();
        int bc;
        bit ok;
        // do_op flips a/b/sub right after acceptance
        do_op(8'h33, 8'h44, 1'b0, bc, ok);
        check_res("stable_33_44", 8'h77, 1'b0, 1'b0, ok);
    endtask

    task automatic test_back_to_back();
        int d_at[$];
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        sub = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (done) d_at.push_back(i);
        end
        start = 1'b0;
        total++;
        if (d_at.size() !== 3)
            $display("FAIL b2b_count: got %0d done pulses, want 3", d_at.size());
        else passed++;
        total++;
        if (d_at.size() < 3)
            $display("FAIL b2b_gap: too few pulses (%0d), want 3", d_at.size());
        else if (d_at[1] - d_at[0] !== 10 || d_at[2] - d_at[1] !== 10)
            $display("FAIL b2b_gap: got %0d,%0d, want 10,10",
                     d_at[1] - d_at[0], d_at[2] - d_at[1]);
        else passed++;
        total++;
        if (sum !== 8'h03) $display("FAIL b2b_sum: got %h, want 03", sum);
        else passed++;
        for (int i = 0; i < 15 && (busy || done); i++) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int bc;
        bit ok;
        bit seen;
        @(negedge clk);
        a = 8'h5A;
        b = 8'h3C;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, sum, cout, ovf} !== 12'h000)
            $display("FAIL mid_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL abort: got busy/done after reset, want none");
        else passed++;
        do_op(8'h01, 8'h01, 1'b0, bc, ok);
        check_res("after_reset", 8'h02, 1'b0, 1'b0, ok);
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_add_carry();
        test_sub();
        test_operand_change();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract sequencer built around a single shared full_adder instance (a, b, cin -> s, cout).
- Latches two WIDTH-bit operands on a start request and feeds them LSB-first through the full adder, one bit per clock, with a carry flip-flop.
- Produces the sum, the carry-out and the signed-overflow flag, then signals completion with a one-cycle done pulse.
- Serves as the area-minimal arithmetic path for processor ops that tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled together with start.
- a  input  WIDTH  operand A; sampled together with start.
- b  input  WIDTH  operand B; sampled together with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE; the operation is aborted and no done pulse is produced.
  - busy, done, sum, cout and ovf go to 0.
  - Internal operand registers, carry flip-flop and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1 at edge N: opA <= a; opB <= sub ? ~b : b; carry <= sub; cnt <= 0; state -> SHIFT.
  - Otherwise hold state.
- SHIFT (busy=1), at each edge:
  - The full_adder is driven with opA[0], opB[0] and carry.
  - The adder's s output shifts into the MSB of the result shift register; opA and opB shift right by one.
  - carry <= adder cout; cnt <= cnt+1.
  - When cnt==WIDTH-2, the pre-MSB carry is captured into c_msb_in.
  - When cnt==WIDTH-1 (the WIDTH-th bit):
    - sum <= final shifted result; cout <= adder cout; ovf <= c_msb_in ^ adder cout.
    - State -> DONE.
- DONE: done=1 for exactly one cycle, then state -> IDLE at the next edge.
- Timing:
  - busy is high from after edge N until edge N+WIDTH.
  - done is high in the cycle following edge N+WIDTH.
  - The next start is accepted at the earliest at edge N+WIDTH+2, so the throughput is one op per WIDTH+2 cycles.
- start is ignored in SHIFT and DONE; requests are not queued.
- Changes to a, b or sub after the accepting edge have no effect on the result.
- sum, cout and ovf are updated only on the transition SHIFT->DONE. They hold their values through IDLE and through the next operation until that operation completes.
- Arithmetic is modulo 2^WIDTH.
- The full_adder is the only arithmetic element. No parallel adder is permitted.

Test Plan:
- After reset: busy=0, done=0, sum=0, cout=0, ovf=0.
- WIDTH=8, add 0x5A+0x3C, start at edge N: busy high for 8 cycles; done in the cycle after edge N+8; sum=0x96, cout=0, ovf=1.
- Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.
- Subtract 0x10-0x20 -> sum=0xF0, cout=0, ovf=0.
- Subtract 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Start held high continuously: ops are accepted every 10 cycles; pulses during SHIFT/DONE are ignored.
- Changing a/b mid-SHIFT does not alter the result.
- rst asserted at cnt=4:
  - All outputs are 0 immediately, with no done pulse.
  - After release, a new add 0x01+0x01 gives sum=0x02.
